// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, producer side of the IF/ID interface.
// Owns the PC, issues in-order memory requests and buffers returned words.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [31:0]     INST_NOP = 32'h0000_0013;
    localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   FULL_C   = CW'(DEPTH);
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_addr;
    logic [31:0]   r_inst  [DEPTH];
    logic [31:0]   r_iaddr [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;

    logic          w_credit;
    logic          w_issue;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;
    logic [31:0]   w_jump_pc;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // Low address bits of a redirect target are forced to word alignment.
    assign w_jump_pc  = jump_addr_i & 32'hFFFF_FFFC;

    // Buffered words plus in-flight requests may never exceed DEPTH.
    assign w_credit   = ({1'b0, r_cnt} + {1'b0, r_out}) < DEPTH_C;
    assign mem_req_o  = ~rst & ~jump_flag_i & w_credit;
    assign mem_addr_o = r_pc;
    assign w_issue    = mem_req_o & mem_gnt_i;

    // A response is stale while discard is non-zero; jump-cycle words die too.
    assign w_rsp      = mem_rvalid_i & (r_out != '0);
    assign w_drop     = w_rsp & (r_disc != '0);
    assign w_push     = w_rsp & (r_disc == '0) & ~jump_flag_i;

    assign w_valid    = (r_cnt != '0) & ~rst;
    assign w_pop      = w_valid & ~hold_flag_i & ~jump_flag_i;

    assign w_wptr_nxt = (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);

    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_inst[r_rptr]  : INST_NOP;
    assign inst_addr_o  = w_valid ? r_iaddr[r_rptr] : 32'h0;

    // PC, credit counters, discard count and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_rsp_addr <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_disc     <= '0;
        end else begin
            r_out <= r_out + CW'(w_issue) - CW'(w_rsp);
            if (jump_flag_i) begin
                // Everything still in flight after this cycle is stale.
                r_pc       <= w_jump_pc;
                r_rsp_addr <= w_jump_pc;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_cnt      <= '0;
                r_disc     <= r_out - CW'(w_rsp);
            end else begin
                if (w_issue)
                    r_pc <= r_pc + 32'd4;
                if (w_drop)
                    r_disc <= r_disc - CW'(1);
                if (w_push) begin
                    r_rsp_addr <= r_rsp_addr + 32'd4;
                    r_wptr     <= w_wptr_nxt;
                end
                if (w_pop)
                    r_rptr <= w_rptr_nxt;
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage: instruction word with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_inst[r_wptr]  <= mem_rdata_i;
            r_iaddr[r_wptr] <= r_rsp_addr;
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_cnt == FULL_C)));

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with an in-order memory model.
// Memory returns addr ^ 32'hA5A5_0000 a configurable number of cycles after gnt.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold_flag_i = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b1;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          lat = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] pop_log[$];

    logic        s_req, s_valid, s_gnt, s_rst;
    logic [31:0] s_addr, s_inst, s_iaddr;

    ifu_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_flag_i  (hold_flag_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, then model memory after posedge.
    task automatic cyc();
        @(negedge clk);
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_iaddr = inst_addr_o;
        s_gnt   = mem_gnt_i;
        s_rst   = rst;
        if (inst_valid_o && !hold_flag_i && !jump_flag_i && !rst) begin
            pop_log.push_back(inst_addr_o);
            chk("inst_word", inst_o, inst_addr_o ^ 32'hA5A5_0000);
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            q_addr.delete();
            q_due.delete();
        end else if (s_req && s_gnt) begin
            q_addr.push_back(s_addr);
            q_due.push_back(cyc_n + lat);
        end
        cyc_n++;
        if (q_due.size() > 0 && q_due[0] <= cyc_n) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = q_addr[0] ^ 32'hA5A5_0000;
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold_flag_i = 1'b0;
        jump_flag_i = 1'b0;
        mem_gnt_i = 1'b1;
        cyc();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        cyc();
        chk("rst_inst", s_inst, 32'h0000_0013);
        chk("rst_iaddr", s_iaddr, 32'h0);
        rst = 1'b0;
        pop_log.delete();
    endtask

    task automatic run_pops(input string tag, input int n, input int budget);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 32'(pop_log.size()), 32'(n));
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base,
                             input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            logic [31:0] g;
            e = base + 32'(4 * i);
            g = (i < pop_log.size()) ? pop_log[i] : 'x;
            chk(tag, g, e);
        end
    endtask

    initial begin
        // Basic streaming from reset, minimum latency.
        lat = 1;
        do_reset();
        cyc();
        chk("c0_req", 32'(s_req), 32'd1);
        chk("c0_addr", s_addr, 32'h0);
        chk("c0_valid", 32'(s_valid), 32'd0);
        cyc();
        chk("c1_valid", 32'(s_valid), 32'd0);
        chk("c1_addr", s_addr, 32'h4);
        cyc();
        chk("c2_valid", 32'(s_valid), 32'd1);
        chk("c2_iaddr", s_iaddr, 32'h0);
        chk("c2_inst", s_inst, 32'hA5A5_0000);
        run_pops("stream_cnt", 6, 40);
        check_seq("stream_seq", 32'h0, 6);

        // Hold with head at 8.
        do_reset();
        begin
            int k = 0;
            while (!(inst_valid_o && inst_addr_o == 32'h8) && k < 20) begin
                cyc();
                k++;
            end
            chk("hold_reach", 32'(k < 20), 32'd1);
        end
        pop_log.delete();
        hold_flag_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_iaddr", s_iaddr, 32'h8);
        end
        chk("hold_req", 32'(s_req), 32'd0);
        chk("hold_nopop", 32'(pop_log.size()), 32'd0);
        hold_flag_i = 1'b0;
        run_pops("hold_cnt", 3, 30);
        check_seq("hold_seq", 32'h8, 3);

        // Jump with two requests outstanding.
        lat = 3;
        do_reset();
        cyc();
        cyc();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0103;
        cyc();
        chk("jmp_req", 32'(s_req), 32'd0);
        jump_flag_i = 1'b0;
        run_pops("jmp_cnt", 2, 40);
        check_seq("jmp_seq", 32'h100, 2);

        // Jump and hold together with full FIFO.
        lat = 1;
        do_reset();
        hold_flag_i = 1'b1;
        repeat (6) cyc();
        chk("full_req", 32'(s_req), 32'd0);
        chk("full_iaddr", s_iaddr, 32'h0);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0200;
        cyc();
        chk("jh_req", 32'(s_req), 32'd0);
        jump_flag_i = 1'b0;
        hold_flag_i = 1'b0;
        cyc();
        chk("jh_valid", 32'(s_valid), 32'd0);
        chk("jh_inst", s_inst, 32'h0000_0013);
        chk("jh_iaddr", s_iaddr, 32'h0);
        chk("jh_addr", s_addr, 32'h200);
        cyc();
        chk("jh_j2_valid", 32'(s_valid), 32'd0);
        cyc();
        chk("jh_j3_valid", 32'(s_valid), 32'd1);
        chk("jh_j3_iaddr", s_iaddr, 32'h200);

        // Ungranted request withdrawn by a jump.
        do_reset();
        mem_gnt_i = 1'b0;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0040;
        cyc();
        jump_flag_i = 1'b0;
        cyc();
        chk("ng_a_addr", s_addr, 32'h40);
        cyc();
        chk("ng_b_req", 32'(s_req), 32'd1);
        chk("ng_b_addr", s_addr, 32'h40);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0080;
        cyc();
        chk("ng_j_req", 32'(s_req), 32'd0);
        jump_flag_i = 1'b0;
        mem_gnt_i = 1'b1;
        cyc();
        chk("ng_d_addr", s_addr, 32'h80);
        run_pops("ng_cnt", 2, 30);
        check_seq("ng_seq", 32'h80, 2);

        // Reset mid-stream with one buffered and one outstanding.
        do_reset();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("mr_valid", 32'(s_valid), 32'd0);
        chk("mr_req", 32'(s_req), 32'd0);
        rst = 1'b0;
        pop_log.delete();
        cyc();
        chk("mr_c0_addr", s_addr, 32'h0);
        run_pops("mr_cnt", 4, 40);
        check_seq("mr_seq", 32'h0, 4);

        // PC wraps past the top of the address space.
        do_reset();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hFFFF_FFF8;
        cyc();
        jump_flag_i = 1'b0;
        run_pops("wrap_cnt", 3, 40);
        check_seq("wrap_seq", 32'hFFFF_FFF8, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
